// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and types for the conv datapath.
// Operand width, feeder FSM encoding and drain length.
package conv_pkg;

  localparam int DW = 8;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN
  } feed_st_t;

  function automatic int drain_len(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/conv_feeder_if.sv
// conv_feeder_if: K-step stream into the feeder.
// One beat = N row weights plus N column features.
interface conv_feeder_if #(
  parameter int N  = 4,
  parameter int DW = 8
);

  logic            s_valid;
  logic            s_ready;
  logic            s_last;
  logic [N*DW-1:0] s_weight;
  logic [N*DW-1:0] s_feature;

  modport master (
    output s_valid,
    output s_last,
    output s_weight,
    output s_feature,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_last,
    input  s_weight,
    input  s_feature,
    output s_ready
  );

endinterface

// File: rtl/conv_feeder_skew_line.sv
// skew_line: DEPTH-stage shift register, async clear.
// DEPTH 0 collapses to a plain wire.
module skew_line #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk;
    assign unused_clk = clk ^ rstn;
    assign q = d;
  end else begin : g_sr
    logic [W-1:0] sr [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int k = 0; k < DEPTH; k++)
          sr[k] <= '0;
      end else begin
        sr[0] <= d;
        for (int k = 1; k < DEPTH; k++)
          sr[k] <= sr[k-1];
      end
    end

    assign q = sr[DEPTH-1];
  end

endmodule

// File: rtl/conv_feeder.sv
// conv_feeder: skews K-steps into the PE array edges,
// drives the clear wavefront and drains between tiles.
module conv_feeder #(
  parameter int N  = 4,
  parameter int DW = conv_pkg::DW
) (
  input  logic            clk,
  input  logic            rstn,
  conv_feeder_if.slave    s,
  output logic [N*DW-1:0] a_weight,
  output logic [N*DW-1:0] a_feature,
  output logic [N-1:0]    a_clr,
  output logic            tile_done,
  output logic            busy
);

  import conv_pkg::*;

  localparam int DRAIN_LEN = drain_len(N);
  localparam int CW = $clog2(DRAIN_LEN + 1);

  feed_st_t        state;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            first_beat;
  logic [N*DW-1:0] r_w;
  logic [N*DW-1:0] r_f;
  logic            r_c;

  assign s.s_ready  = (state != DRAIN);
  assign busy       = (state != IDLE);
  assign accept     = s.s_valid && s.s_ready;
  assign first_beat = (state == IDLE);

  // Non-accept cycles load zeros, so the array sees bubbles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      tile_done <= 1'b0;
      r_w       <= '0;
      r_f       <= '0;
      r_c       <= 1'b0;
    end else begin
      tile_done <= 1'b0;
      r_w       <= accept ? s.s_weight : '0;
      r_f       <= accept ? s.s_feature : '0;
      r_c       <= accept && first_beat;
      unique case (state)
        IDLE, FEED: begin
          if (accept) begin
            if (s.s_last) begin
              state <= DRAIN;
              cnt   <= CW'(DRAIN_LEN);
            end else begin
              state <= FEED;
            end
          end
        end
        DRAIN: begin
          if (cnt == CW'(1)) begin
            state     <= IDLE;
            cnt       <= '0;
            tile_done <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW:0]   wq;
    logic [DW-1:0] fq;

    skew_line #(.DEPTH(i), .W(DW + 1)) u_w (
      .clk  (clk),
      .rstn (rstn),
      .d    ({r_c, r_w[i*DW +: DW]}),
      .q    (wq)
    );

    skew_line #(.DEPTH(i), .W(DW)) u_f (
      .clk  (clk),
      .rstn (rstn),
      .d    (r_f[i*DW +: DW]),
      .q    (fq)
    );

    assign a_clr[i]              = wq[DW];
    assign a_weight[i*DW +: DW]  = wq[DW-1:0];
    assign a_feature[i*DW +: DW] = fq;
  end

endmodule

// File: tb/tb_conv_feeder.sv
// tb_conv_feeder: directed bench with a beat-history model
// and a 4x4 output-stationary PE array behind the feeder.
module tb_conv_feeder;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int NE = 4096;

  logic            clk  = 1'b0;
  logic            rstn = 1'b1;
  logic [N*DW-1:0] a_weight;
  logic [N*DW-1:0] a_feature;
  logic [N-1:0]    a_clr;
  logic            tile_done;
  logic            busy;

  conv_feeder_if #(.N(N), .DW(DW)) dif ();

  conv_feeder #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .s         (dif),
    .a_weight  (a_weight),
    .a_feature (a_feature),
    .a_clr     (a_clr),
    .tile_done (tile_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;

  // Beat history indexed by edge number; cycle c follows edge c-1.
  int          ecount = 0;
  bit          acc_v [NE];
  logic [31:0] acc_w [NE];
  logic [31:0] acc_f [NE];
  bit          acc_c [NE];
  bit          open;
  int          drain_end = -1;
  int          tsum    [N][N];
  int          exp_sum [N][N];

  logic signed [7:0] pw [N][N];
  logic signed [7:0] pf [N][N];
  bit                pc [N][N];
  logic signed [7:0] nw [N][N];
  logic signed [7:0] nf [N][N];
  bit                nc [N][N];
  int                acc [N][N];
  int                clr_cnt [N];

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pack4(input int a, input int b,
                                        input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  // Model of accepted beats plus the downstream PE array.
  always @(posedge clk) begin : model
    logic signed [7:0] win;
    logic signed [7:0] fin;
    bit                cin;
    int                p;
    if (!rstn) begin
      foreach (acc_v[e]) acc_v[e] = 1'b0;
      open      = 1'b0;
      drain_end = -1;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          pw[i][j] = '0;
          pf[i][j] = '0;
          pc[i][j] = 1'b0;
        end
    end else begin
      if (dif.s_valid && dif.s_ready && ecount < NE) begin
        acc_v[ecount] = 1'b1;
        acc_w[ecount] = dif.s_weight;
        acc_f[ecount] = dif.s_feature;
        acc_c[ecount] = !open;
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) begin
            p = int'($signed(dif.s_weight[i*DW +: DW])) *
                int'($signed(dif.s_feature[j*DW +: DW]));
            tsum[i][j] = open ? tsum[i][j] + p : p;
          end
        if (dif.s_last) begin
          open      = 1'b0;
          drain_end = ecount + 2 * N;
          exp_sum   = tsum;
        end else begin
          open = 1'b1;
        end
      end
      for (int i = 0; i < N; i++) begin
        clr_cnt[i] += int'(a_clr[i]);
        for (int j = 0; j < N; j++) begin
          if (j == 0) begin
            win = $signed(a_weight[i*DW +: DW]);
            cin = a_clr[i];
          end else begin
            win = pw[i][j-1];
            cin = pc[i][j-1];
          end
          if (i == 0) fin = $signed(a_feature[j*DW +: DW]);
          else        fin = pf[i-1][j];
          p = int'(win) * int'(fin);
          acc[i][j] = cin ? p : acc[i][j] + p;
          nw[i][j] = win;
          nf[i][j] = fin;
          nc[i][j] = cin;
        end
      end
      pw = nw;
      pf = nf;
      pc = nc;
    end
    ecount++;
  end

  always @(negedge clk) begin : compare
    logic [31:0] ew;
    logic [31:0] ef;
    logic [3:0]  ec;
    int          c;
    int          e;
    if (!rstn) begin
      chk("rst_a_weight", a_weight, 0);
      chk("rst_a_feature", a_feature, 0);
      chk("rst_a_clr", a_clr, 0);
      chk("rst_tile_done", tile_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_s_ready", dif.s_ready, 1);
    end else begin
      c  = ecount;
      ew = '0;
      ef = '0;
      ec = '0;
      for (int k = 0; k < N; k++) begin
        e = c - 1 - k;
        if (e >= 0 && e < NE && acc_v[e]) begin
          ew[k*DW +: DW] = acc_w[e][k*DW +: DW];
          ef[k*DW +: DW] = acc_f[e][k*DW +: DW];
          ec[k]          = acc_c[e];
        end
      end
      chk("a_weight", a_weight, ew);
      chk("a_feature", a_feature, ef);
      chk("a_clr", a_clr, ec);
      chk("tile_done", tile_done, c == drain_end);
      chk("s_ready", dif.s_ready, !(c < drain_end));
      chk("busy", busy, open || (c < drain_end));
      if (c == drain_end)
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            chk("pe_sum", acc[i][j], exp_sum[i][j]);
    end
  end

  task automatic beat(input logic [31:0] w, input logic [31:0] f,
                      input bit last, output int t);
    int base;
    bit got;
    bit rdy;
    int n;
    got = 1'b0;
    t   = -1;
    n   = 0;
    @(negedge clk);
    dif.s_valid   = 1'b1;
    dif.s_last    = last;
    dif.s_weight  = w;
    dif.s_feature = f;
    base = ecount;
    while (!got && n < 40) begin
      rdy = dif.s_ready;
      @(posedge clk);
      if (rdy) begin
        got = 1'b1;
        t   = base + n;
      end else begin
        n++;
        @(negedge clk);
      end
    end
    if (!got) begin
      nchk++;
      nerr++;
      $display("FAIL accept_timeout: no accept in 40 cycles");
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    dif.s_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic wait_done(output int c);
    bit got;
    got = 1'b0;
    c   = -1;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      dif.s_valid = 1'b0;
      if (tile_done) begin
        got = 1'b1;
        c   = ecount;
      end
    end
    if (!got) begin
      nchk++;
      nerr++;
      $display("FAIL done_timeout: no tile_done in 40 cycles");
    end
  endtask

  task automatic clear_clr_cnt();
    for (int i = 0; i < N; i++) clr_cnt[i] = 0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] w2;
    logic [31:0] fm3;
    int t0, t1, t2, dc;
    w2  = pack4(2, 2, 2, 2);
    fm3 = pack4(-3, -3, -3, -3);
    dif.s_valid   = 1'b0;
    dif.s_last    = 1'b0;
    dif.s_weight  = '0;
    dif.s_feature = '0;
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    #1 rstn = 1'b1;

    repeat (5) begin
      @(negedge clk);
      chk("idle_ready", dif.s_ready, 1);
      chk("idle_busy", busy, 0);
      chk("idle_done", tile_done, 0);
      chk("idle_weight", a_weight, 0);
    end

    beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b1, t0);
    @(negedge clk);
    dif.s_valid = 1'b0;
    chk("single_w0", a_weight[7:0], 1);
    chk("single_clr0", a_clr[0], 1);
    repeat (3) @(negedge clk);
    chk("single_w3", a_weight[31:24], 4);
    chk("single_clr3", a_clr[3], 1);
    chk("single_f3", a_feature[31:24], 8);
    repeat (3) @(negedge clk);
    chk("single_done_t7", tile_done, 0);
    @(negedge clk);
    chk("single_done_t8", tile_done, 1);
    chk("single_sum33", acc[3][3], 32);
    chk("single_sum01", acc[0][1], 6);

    clear_clr_cnt();
    beat(w2, fm3, 1'b0, t0);
    beat(w2, fm3, 1'b0, t1);
    beat(w2, fm3, 1'b1, t2);
    wait_done(dc);
    chk("k3_latency", dc - t0, 10);
    chk("k3_sum00", acc[0][0], -18);
    chk("k3_sum33", acc[3][3], -18);
    chk("k3_sum12", acc[1][2], -18);
    for (int i = 0; i < N; i++)
      chk("k3_clr_per_row", clr_cnt[i], 1);

    clear_clr_cnt();
    beat(w2, fm3, 1'b0, t0);
    beat(w2, fm3, 1'b0, t1);
    idle(2);
    beat(w2, fm3, 1'b1, t2);
    wait_done(dc);
    chk("stall_gap", t2 - t1, 3);
    chk("stall_latency", dc - t0, 12);
    chk("stall_sum00", acc[0][0], -18);
    chk("stall_sum33", acc[3][3], -18);
    for (int i = 0; i < N; i++)
      chk("stall_clr_per_row", clr_cnt[i], 1);

    beat(w2, fm3, 1'b0, t0);
    beat(w2, fm3, 1'b0, t1);
    beat(w2, fm3, 1'b1, t2);
    beat(pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), 1'b1, t1);
    chk("b2b_accept_edge", t1 - t2, 8);
    @(negedge clk);
    dif.s_valid = 1'b0;
    chk("b2b_clr0", a_clr[0], 1);
    wait_done(dc);
    chk("b2b_latency", dc - t1, 8);
    chk("b2b_sum00", acc[0][0], 1);
    chk("b2b_sum33", acc[3][3], 4);
    chk("b2b_sum30", acc[3][0], 4);
    chk("b2b_sum03", acc[0][3], 1);

    beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b1, t0);
    @(negedge clk);
    dif.s_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("mid_rst_weight", a_weight, 0);
    chk("mid_rst_feature", a_feature, 0);
    chk("mid_rst_clr", a_clr, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", dif.s_ready, 1);
    chk("mid_rst_done", tile_done, 0);
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("post_rst_no_done", tile_done, 0);
    end

    beat(w2, fm3, 1'b0, t0);
    beat(w2, fm3, 1'b0, t1);
    beat(w2, fm3, 1'b1, t2);
    wait_done(dc);
    chk("fresh_latency", dc - t0, 10);
    chk("fresh_sum00", acc[0][0], -18);
    chk("fresh_sum33", acc[3][3], -18);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/conv_feeder.md
# conv_feeder

Input skew and control stage that sits directly upstream of the N×N output-stationary PE array in the conv module. It accepts one K-step per handshake (N weights for the array rows, N features for the array columns), applies the diagonal skew, and generates the per-row clear wavefront. Between tiles it injects zero bubbles so that finished accumulators stay stable, then signals completion.

## Interface
- N, 4: array dimension (rows = columns = N); N ≥ 2
- DW, 8: operand width, signed two's complement
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- s_valid  in  1  upstream beat valid
- s_ready  out  1  feeder accepts a beat this cycle
- s_last  in  1  beat is the final K-step of the tile
- s_weight  in  N*DW  lane i, bits [i*DW +: DW], is the weight for array row i
- s_feature  in  N*DW  lane j is the feature for array column j
- a_weight  out  N*DW  lane i drives the left in_weight of PE(i,0)
- a_feature  out  N*DW  lane j drives the top in_feature of PE(0,j)
- a_clr  out  N  bit i drives the left in_clr of PE(i,0)
- tile_done  out  1  one-cycle pulse; all N×N sums are final
- busy  out  1  state ≠ IDLE

## Operation
- Accept when s_valid && s_ready.
- FSM states:
  - IDLE: s_ready=1. On accept, go to FEED, or directly to DRAIN if s_last.
  - FEED: s_ready=1. On accept with s_last, go to DRAIN.
  - DRAIN: s_ready=0. Down-counter loaded with 2N-1 on entry. At zero, pulse tile_done and go to IDLE.
- The first beat accepted from IDLE carries clr=1 on every row. All other beats carry clr=0.
- A cycle with no accept (stall in FEED, any DRAIN cycle, IDLE) injects a bubble: weight=0, feature=0, clr=0. PEs then add 0, so sums hold.
- Skew:
  - Weight lane i and clr bit i are delayed i extra cycles.
  - Feature lane j is delayed j extra cycles.
  - Lane 0 has only the output register.
- Operands pass through unmodified; there is no arithmetic on data.
- Single-beat tile (first beat also s_last): clr=1 on that beat, then DRAIN.
- After tile_done, sums stay stable until the next tile's clr reaches each PE.
- Reset mid-operation: all skew registers, counter and outputs clear, state returns to IDLE, and no tile_done is emitted.

## Timing
- All outputs are registered. Reset values:
  - a_weight=0, a_feature=0, a_clr=0, tile_done=0, busy=0
  - s_ready=1 (combinational from state; IDLE after reset)
- Beat accepted at edge T:
  - appears on lane 0 in cycle T+1;
  - appears on lane k in cycle T+1+k;
  - reaches PE(i,j) in cycle T+1+i+j.
- Last beat accepted at edge T:
  - DRAIN occupies cycles T+1 … T+2N-1 with s_ready=0;
  - tile_done is high in cycle T+2N only;
  - s_ready returns to 1 in cycle T+2N, so the next tile's first beat may be accepted at that edge.
- Throughput: one K-step per cycle while in FEED. Per-tile overhead is 2N-1 cycles.
- s_ready does not depend combinationally on s_valid.

## Structure
- Shared package conv_pkg holds:
  - DW;
  - FSM state encoding (IDLE, FEED, DRAIN);
  - the drain-length constant expression 2N-1.
- One sub-module, skew_line(DEPTH, W): a W-bit shift register of DEPTH stages with async active-low reset to zero.
  - Instantiated per weight lane (W=DW+1, carrying clr) and per feature lane (W=DW).
  - DEPTH=k for lane k; DEPTH 0 is a wire.
- The top level contains the FSM, the first-beat flag, the drain counter and the output register stage.

## Test plan
Directed scenarios for the bench, with N=4:
- Reset, idle 5 cycles: all outputs 0, s_ready=1, busy=0, no tile_done.
- One beat, weight lanes {1,2,3,4}, features {5,6,7,8}, s_last=1:
  - a_weight[0]=1 with a_clr[0]=1 in cycle T+1;
  - a_weight[3]=4 with a_clr[3]=1 in cycle T+4;
  - a_feature[3]=8 in cycle T+4;
  - tile_done in cycle T+8.
- 3-beat tile, all weights 2, all features -3 (K=3), behind a 4-row model array: every sum is -18 at tile_done; exactly one clr per row, on beat 0 only.
- Same tile with s_valid low for 2 cycles between beats 1 and 2: sums still -18; tile_done moves 2 cycles later.
- Back-to-back tiles (second tile's first beat presented during DRAIN):
  - s_ready=0 until cycle T+8;
  - the second beat is accepted at that edge with clr=1;
  - the second tile's sums exclude the first tile's values.
- rstn asserted in DRAIN cycle T+3:
  - outputs are 0 immediately;
  - no tile_done;
  - a fresh tile after release completes normally.
